// File: rtl/input_poll_controller.sv
// rtl/input_poll_controller.sv - keyboard poll FSM with key FIFO and CPU register port
// Polls the input device every poll_div cycles, queues key codes and keeps the last random byte.
module input_poll_controller #(
  parameter int DEPTH    = 8,
  parameter int POLL_DIV = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        dev_read,
  input  logic [31:0] dev_data,
  input  logic        cpu_sel,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        irq
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RAND   = 2'd3;

  typedef enum logic [1:0] {
    S_DISABLED,
    S_PRIME,
    S_WAIT,
    S_STROBE
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     wait_cnt_q, wait_cnt_d;

  logic           enable_q, enable_d;
  logic           irq_en_q, irq_en_d;
  logic [7:0]     poll_div_q, poll_div_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     rand_q, rand_d;

  logic [7:0]     mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [4:0]     count_q, count_d;

  logic           wr_en, rd_en;
  logic           empty, full;
  logic           pop, sample, key_valid, push;
  logic           ovf_set, ovf_clr;
  logic           fast_poll;
  logic [31:0]    rdata_mux;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_en     = cpu_sel && cpu_write;
  assign rd_en     = cpu_sel && !cpu_write;
  assign empty     = (count_q == 5'd0);
  assign full      = (count_q == 5'(DEPTH));
  assign fast_poll = (poll_div_q <= 8'd1);

  // The device answer on a strobe edge belongs to the previous strobe; a PRIME
  // cycle only arms the device, so sampling is restricted to STROBE.
  assign sample    = (state_q == S_STROBE) && enable_q;
  assign key_valid = sample && (dev_data[31:24] != 8'hFF);
  assign pop       = rd_en && (cpu_addr == ADDR_DATA) && !empty;
  assign push      = key_valid && (!full || pop);
  assign ovf_set   = key_valid && full && !pop;
  assign ovf_clr   = wr_en && (cpu_addr == ADDR_STATUS) && cpu_wdata[10];

  assign dev_read  = enable_q && ((state_q == S_PRIME) || (state_q == S_STROBE));
  assign irq       = irq_en_q && !empty;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (!enable_q) begin
      state_d = S_DISABLED;
    end else begin
      case (state_q)
        S_DISABLED: state_d = S_PRIME;
        S_PRIME, S_STROBE: begin
          if (fast_poll) begin
            state_d = S_STROBE;
          end else begin
            state_d    = S_WAIT;
            wait_cnt_d = 8'd0;
          end
        end
        S_WAIT: begin
          // WAIT spans poll_div-1 cycles; >= tolerates poll_div shrinking mid-wait.
          if (fast_poll || (wait_cnt_q >= poll_div_q - 8'd2)) begin
            state_d = S_STROBE;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
        default: state_d = S_DISABLED;
      endcase
    end
  end

  always_comb begin
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    poll_div_d = poll_div_q;
    rand_d     = rand_q;
    overflow_d = ovf_set || (overflow_q && !ovf_clr);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (wr_en && (cpu_addr == ADDR_CTRL)) begin
      poll_div_d = cpu_wdata[15:8];
      irq_en_d   = cpu_wdata[1];
      enable_d   = cpu_wdata[0];
    end

    if (key_valid) begin
      rand_d = dev_data[7:0];
    end

    if (push) begin
      wr_ptr_d = ptr_next(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_DISABLED;
      wait_cnt_q <= 8'd0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      poll_div_q <= 8'(POLL_DIV);
      overflow_q <= 1'b0;
      rand_q     <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      poll_div_q <= poll_div_d;
      overflow_q <= overflow_d;
      rand_q     <= rand_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= dev_data[31:24];
    end
  end

  always_comb begin
    rdata_mux = 32'h0;
    case (cpu_addr)
      ADDR_DATA:   rdata_mux = empty ? 32'hFF00_0000 : {24'h0, mem_q[rd_ptr_q]};
      ADDR_STATUS: rdata_mux = {21'h0, overflow_q, full, empty, 3'h0, count_q};
      ADDR_CTRL:   rdata_mux = {16'h0, poll_div_q, 6'h0, irq_en_q, enable_q};
      ADDR_RAND:   rdata_mux = {24'h0, rand_q};
      default:     rdata_mux = 32'h0;
    endcase
  end

  assign cpu_rdata = rd_en ? rdata_mux : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_input_poll_controller.sv
// tb/tb_input_poll_controller.sv - directed bench for input_poll_controller
// Linear directed steps; expected values are hand-derived cycle by cycle.
module tb_input_poll_controller;

  logic        clock;
  logic        reset;
  logic        dev_read;
  logic [31:0] dev_data;
  logic        cpu_sel;
  logic        cpu_write;
  logic [1:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  wire  [31:0] cpu_rdata;
  logic        irq;

  int checks;
  int failures;

  input_poll_controller #(.DEPTH(8), .POLL_DIV(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .dev_read  (dev_read),
    .dev_data  (dev_data),
    .cpu_sel   (cpu_sel),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .irq       (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
    cpu_sel   = 1'b1;
    cpu_write = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    tick();
    cpu_sel   = 1'b0;
    cpu_write = 1'b0;
    cpu_wdata = 32'h0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cpu_sel   = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = a;
    #1;
    d = cpu_rdata;
    cpu_sel   = 1'b0;
    chk(tag, d, exp);
  endtask

  task automatic chk_pop(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    cpu_sel   = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = 2'd0;
    #1;
    d = cpu_rdata;
    tick();
    cpu_sel   = 1'b0;
    chk(tag, d, exp);
  endtask

  logic [7:0] drain_keys [8];

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    dev_data  = 32'hFF00_0000;
    cpu_sel   = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = 2'd0;
    cpu_wdata = 32'h0;
    drain_keys = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h59};

    repeat (2) tick();
    chk("rst_dev_read_during", {31'h0, dev_read}, 32'h0);
    chk("rst_irq_during", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    tick();
    chk_reg("rst_status", 2'd1, 32'h0000_0100);
    chk_reg("rst_ctrl", 2'd2, 32'h0000_1000);
    chk_reg("rst_rand", 2'd3, 32'h0000_0000);
    chk("rst_dev_read", {31'h0, dev_read}, 32'h0);

    // poll_div 4: PRIME one cycle, then a STROBE every 4 cycles
    cpu_wr(2'd2, 32'h0000_0401);
    chk("disabled_before_prime", {31'h0, dev_read}, 32'h0);
    tick();
    chk("prime_read", {31'h0, dev_read}, 32'h1);
    dev_data = 32'h4000_0011;
    tick();
    chk("wait_after_prime", {31'h0, dev_read}, 32'h0);
    dev_data = 32'h4100_0055;
    tick();
    tick();
    chk("wait_third_cycle", {31'h0, dev_read}, 32'h0);
    tick();
    chk("strobe1_read", {31'h0, dev_read}, 32'h1);
    tick();
    chk_reg("status_one_key", 2'd1, 32'h0000_0001);
    chk_reg("rand_after_41", 2'd3, 32'h0000_0055);
    dev_data = 32'h4200_0066;
    tick();
    tick();
    chk("wait_before_strobe2", {31'h0, dev_read}, 32'h0);
    tick();
    chk("strobe2_read", {31'h0, dev_read}, 32'h1);
    tick();
    dev_data = 32'hFF00_0000;
    chk_reg("status_two_keys", 2'd1, 32'h0000_0002);
    chk("irq_masked", {31'h0, irq}, 32'h0);
    chk_pop("pop_first_41", 32'h0000_0041);
    chk_pop("pop_second_42", 32'h0000_0042);
    chk_reg("status_drained", 2'd1, 32'h0000_0100);

    // device reports no key only
    cpu_wr(2'd2, 32'h0000_0403);
    repeat (10) tick();
    chk_reg("nokey_status", 2'd1, 32'h0000_0100);
    chk_reg("nokey_rand", 2'd3, 32'h0000_0066);
    chk("nokey_irq", {31'h0, irq}, 32'h0);

    // nine keys at one strobe per cycle into an 8-deep FIFO
    cpu_wr(2'd2, 32'h0000_0002);
    tick();
    cpu_wr(2'd2, 32'h0000_0103);
    tick();
    tick();
    chk("fast_strobe_after_prime", {31'h0, dev_read}, 32'h1);
    for (int i = 0; i < 9; i++) begin
      dev_data = {8'(8'h50 + i), 16'h0, 8'(8'hA0 + i)};
      tick();
    end
    dev_data = 32'hFF00_0000;
    chk_reg("overflow_status", 2'd1, 32'h0000_0608);
    chk("full_irq", {31'h0, irq}, 32'h1);
    cpu_wr(2'd1, 32'h0000_0400);
    chk_reg("overflow_cleared", 2'd1, 32'h0000_0208);

    // pop and push on the same strobe edge while full
    dev_data = 32'h5900_00B9;
    chk_pop("full_pop_head", 32'h0000_0050);
    dev_data = 32'hFF00_0000;
    chk_reg("full_swap_status", 2'd1, 32'h0000_0208);
    chk_reg("full_swap_rand", 2'd3, 32'h0000_00B9);
    for (int i = 0; i < 8; i++) begin
      chk_pop($sformatf("drain_%0d", i), {24'h0, drain_keys[i]});
    end
    chk_pop("empty_data", 32'hFF00_0000);
    chk_reg("empty_status", 2'd1, 32'h0000_0100);

    // poll_div 0: strobe every cycle after PRIME, stop when disabled
    cpu_wr(2'd2, 32'h0000_0000);
    tick();
    cpu_wr(2'd2, 32'h0000_0001);
    tick();
    chk("div0_prime", {31'h0, dev_read}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("div0_strobe_%0d", i), {31'h0, dev_read}, 32'h1);
    end
    cpu_wr(2'd2, 32'h0000_0000);
    tick();
    chk("disable_read_low", {31'h0, dev_read}, 32'h0);
    chk_reg("disable_ctrl", 2'd2, 32'h0000_0000);

    // reset while waiting with three keys queued
    dev_data = 32'h6100_0001;
    cpu_wr(2'd2, 32'h0000_0403);
    repeat (14) tick();
    chk_reg("pre_reset_status", 2'd1, 32'h0000_0003);
    chk("pre_reset_irq", {31'h0, irq}, 32'h1);
    chk("pre_reset_wait", {31'h0, dev_read}, 32'h0);
    reset = 1'b1;
    tick();
    chk("mid_reset_dev_read", {31'h0, dev_read}, 32'h0);
    chk("mid_reset_irq", {31'h0, irq}, 32'h0);
    chk_reg("mid_reset_status", 2'd1, 32'h0000_0100);
    chk_reg("mid_reset_ctrl", 2'd2, 32'h0000_1000);
    reset = 1'b0;
    dev_data = 32'hFF00_0000;
    repeat (3) tick();
    chk("post_reset_idle", {31'h0, dev_read}, 32'h0);
    chk_reg("post_reset_rand", 2'd3, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
